tow_pixel_renderer: RTL

- Downstream of vga_controller. Consumes hpos/vpos/pixel_on/hSync/vSync and the game state; produces the 8-bit RGB332 pixel plus hSync/vSync delayed to stay aligned with it.
- Game state is sampled once per frame so a frame never tears. A small FSM drives the winner flash/hold display.
- Output feeds the board VGA DAC pins directly.

---
 rtl/tow_pkg.sv | 39 +++
 rtl/tow_frame_fsm.sv | 94 +++++++++
 rtl/tow_pixel_renderer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/tow_pkg.sv
// Shared constants and types for the tug-of-war pixel renderer:
// RGB332 palette, screen geometry, row bounds and the flash/hold state enum.
package tow_pkg;

  localparam logic [7:0] RGB_BLACK  = 8'h00;
  localparam logic [7:0] RGB_WHITE  = 8'hFF;
  localparam logic [7:0] RGB_CENTRE = 8'hE0;
  localparam logic [7:0] RGB_ROPE   = 8'hB4;
  localparam logic [7:0] RGB_LEFT   = 8'h03;
  localparam logic [7:0] RGB_RIGHT  = 8'h1C;

  localparam logic [9:0] SCR_X_LAST = 10'd639;
  localparam logic [9:0] SCR_Y_LAST = 10'd479;
  localparam logic [9:0] CENTRE_X   = 10'd320;

  localparam logic [9:0] MARKER_Y0 = 10'd224;
  localparam logic [9:0] MARKER_Y1 = 10'd255;
  localparam logic [9:0] ROPE_Y0   = 10'd236;
  localparam logic [9:0] ROPE_Y1   = 10'd243;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    FLASH = 2'd1,
    HOLD  = 2'd2
  } tow_state_e;

  function automatic logic [7:0] winner_rgb(input logic [1:0] w);
    case (w)
      WIN_LEFT:  return RGB_LEFT;
      WIN_RIGHT: return RGB_RIGHT;
      default:   return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/tow_frame_fsm.sv
// Frame-edge detection, once-per-frame game-state latch and the winner
// flash/hold state machine.
module tow_frame_fsm
  import tow_pkg::*;
#(
  parameter int POS_W        = 5,
  parameter int BLINK_FRAMES = 15,
  parameter int FLASH_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vsync_p1,
  input  logic                    vsync_p2,
  input  logic signed [POS_W-1:0] rope_pos,
  input  logic [1:0]              winner,
  output logic                    frame_tick,
  output logic signed [POS_W-1:0] pos_l,
  output logic [1:0]              win_l,
  output logic                    bg_winner_on
);

  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int PW = $clog2(2 * FLASH_CYCLES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(2 * FLASH_CYCLES - 1);

  tow_state_e    state_q, state_n;
  logic [BW-1:0] blink_q, blink_n;
  logic [PW-1:0] phase_q, phase_n;
  logic [1:0]    win_in;

  assign win_in = (winner == 2'b11) ? WIN_NONE : winner;

  always_comb begin
    state_n = state_q;
    blink_n = blink_q;
    phase_n = phase_q;
    case (state_q)
      PLAY: begin
        if (win_in != WIN_NONE) begin
          state_n = FLASH;
          blink_n = '0;
          phase_n = '0;
        end
      end
      FLASH: begin
        if (win_in == WIN_NONE) begin
          state_n = PLAY;
          blink_n = '0;
          phase_n = '0;
        end else if (blink_q == BLINK_LAST) begin
          blink_n = '0;
          if (phase_q == PHASE_LAST) begin
            state_n = HOLD;
            phase_n = '0;
          end else begin
            phase_n = phase_q + PW'(1);
          end
        end else begin
          blink_n = blink_q + BW'(1);
        end
      end
      HOLD: begin
        if (win_in == WIN_NONE) state_n = PLAY;
      end
      default: state_n = PLAY;
    endcase
  end

  // Latch and FSM advance together so the whole next frame sees one state
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_tick <= 1'b0;
      pos_l      <= '0;
      win_l      <= WIN_NONE;
      state_q    <= PLAY;
      blink_q    <= '0;
      phase_q    <= '0;
    end else begin
      frame_tick <= vsync_p2 & ~vsync_p1;
      if (frame_tick) begin
        pos_l   <= rope_pos;
        // once a side has won, only a clear may replace it
        if (state_q == PLAY || win_in == WIN_NONE) win_l <= win_in;
        state_q <= state_n;
        blink_q <= blink_n;
        phase_q <= phase_n;
      end
    end
  end

  assign bg_winner_on = (state_q == HOLD) || (state_q == FLASH && phase_q[0]);

endmodule

// File: rtl/tow_pixel_renderer.sv
// Tug-of-war pixel renderer: region compare plus 2-stage RGB332 pipeline.
// Optional macro TOW_BORDER_EN adds a 1-px white screen border at top priority.
module tow_pixel_renderer
  import tow_pkg::*;
#(
  parameter int POS_W        = 5,
  parameter int STEP_PX      = 8,
  parameter int GOAL_POS     = 6,
  parameter int BLINK_FRAMES = 15,
  parameter int FLASH_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [9:0]              hpos,
  input  logic [9:0]              vpos,
  input  logic                    pixel_on,
  input  logic                    hSync,
  input  logic                    vSync,
  input  logic signed [POS_W-1:0] rope_pos,
  input  logic [1:0]              winner,
  output logic [7:0]              rgb,
  output logic                    hSync_out,
  output logic                    vSync_out,
  output logic                    frame_tick
);

  localparam logic signed [10:0] CENTRE_S = 11'sd320;
  localparam logic signed [10:0] STEP_S   = 11'(STEP_PX);
  localparam int                 GOAL_OFF = GOAL_POS * STEP_PX;
  localparam logic [9:0]         GOAL_L_X = 10'(320 - GOAL_OFF);
  localparam logic [9:0]         GOAL_R_X = 10'(320 + GOAL_OFF);

  logic signed [POS_W-1:0] pos_l;
  logic [1:0]              win_l;
  logic                    bg_on;

  logic signed [10:0] pos_ext, mx;
  logic signed [11:0] dx;
  logic marker_hit, centre_hit, rope_hit, goal_l_hit, goal_r_hit;

  logic on_p1, hs_p1, vs_p1;
  logic marker_p1, centre_p1, rope_p1, goal_l_p1, goal_r_p1;
  logic [7:0] colour;
  logic [7:0] rgb_p2;
  logic hs_p2, vs_p2;

  tow_frame_fsm #(
    .POS_W        (POS_W),
    .BLINK_FRAMES (BLINK_FRAMES),
    .FLASH_CYCLES (FLASH_CYCLES)
  ) u_fsm (
    .clk          (clk),
    .rst          (rst),
    .vsync_p1     (vs_p1),
    .vsync_p2     (vs_p2),
    .rope_pos     (rope_pos),
    .winner       (winner),
    .frame_tick   (frame_tick),
    .pos_l        (pos_l),
    .win_l        (win_l),
    .bg_winner_on (bg_on)
  );

  // Marker distance kept in 12 bits so off-screen mx never aliases onto the screen
  assign pos_ext = {{(11 - POS_W){pos_l[POS_W-1]}}, pos_l};
  assign mx      = CENTRE_S + pos_ext * STEP_S;
  assign dx      = $signed({2'b00, hpos}) - $signed({mx[10], mx});

  assign marker_hit = (dx > -12'sd8) && (dx < 12'sd8) &&
                      (vpos >= MARKER_Y0) && (vpos <= MARKER_Y1);
  assign centre_hit = (hpos == CENTRE_X - 10'd1) || (hpos == CENTRE_X);
  assign rope_hit   = (vpos >= ROPE_Y0) && (vpos <= ROPE_Y1);
  assign goal_l_hit = (hpos == GOAL_L_X) || (hpos == GOAL_L_X + 10'd1);
  assign goal_r_hit = (hpos == GOAL_R_X) || (hpos == GOAL_R_X + 10'd1);

`ifdef TOW_BORDER_EN
  logic border_hit, border_p1;
  assign border_hit = (hpos == 10'd0) || (hpos == SCR_X_LAST) ||
                      (vpos == 10'd0) || (vpos == SCR_Y_LAST);
  always_ff @(posedge clk) begin
    if (rst) border_p1 <= 1'b0;
    else     border_p1 <= border_hit;
  end
`endif

  // Stage 1: register sync, visibility and region hits
  always_ff @(posedge clk) begin
    if (rst) begin
      on_p1     <= 1'b0;
      hs_p1     <= 1'b1;
      vs_p1     <= 1'b1;
      marker_p1 <= 1'b0;
      centre_p1 <= 1'b0;
      rope_p1   <= 1'b0;
      goal_l_p1 <= 1'b0;
      goal_r_p1 <= 1'b0;
    end else begin
      on_p1     <= pixel_on;
      hs_p1     <= hSync;
      vs_p1     <= vSync;
      marker_p1 <= marker_hit;
      centre_p1 <= centre_hit;
      rope_p1   <= rope_hit;
      goal_l_p1 <= goal_l_hit;
      goal_r_p1 <= goal_r_hit;
    end
  end

  always_comb begin
    colour = bg_on ? winner_rgb(win_l) : RGB_BLACK;
    if (goal_r_p1) colour = RGB_RIGHT;
    if (goal_l_p1) colour = RGB_LEFT;
    if (rope_p1)   colour = RGB_ROPE;
    if (centre_p1) colour = RGB_CENTRE;
    if (marker_p1) colour = RGB_WHITE;
`ifdef TOW_BORDER_EN
    if (border_p1) colour = RGB_WHITE;
`endif
    if (!on_p1)    colour = RGB_BLACK;
  end

  // Stage 2: register colour and aligned syncs
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_p2 <= RGB_BLACK;
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
    end else begin
      rgb_p2 <= colour;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
    end
  end

  assign rgb       = rgb_p2;
  assign hSync_out = hs_p2;
  assign vSync_out = vs_p2;

endmodule
